// File: rtl/sync1011_pkg.sv
// sync1011_pkg: state encodings, sync header constants and counter sizing for sync1011_tx.
// Revision 1.0 - initial release.
`default_nettype none

package sync1011_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_PAT = 4'b1011;
  localparam int         SYNC_LEN = 4;

  // Counter must hold the longest phase length minus one.
  function automatic int cnt_width(input int dw, input int gap);
    int m;
    m = SYNC_LEN;
    if (dw > m) m = dw;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync1011_shreg.sv
// sync1011_shreg: parallel-load, shift-left register; serial output is the MSB.
// Revision 1.0 - initial release.
`default_nettype none

module sync1011_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         sout_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign sout_o = sr_q[W-1];

endmodule

`default_nettype wire

// File: rtl/sync1011_tx.sv
// sync1011_tx: serial framer emitting a 1011 header, an MSB-first payload and a zero gap.
// Revision 1.0 - initial release.
`default_nettype none

module sync1011_tx
  import sync1011_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              z,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(DATA_W, GAP);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, sout;

  sync1011_shreg #(.W(DATA_W)) u_shreg (
    .clk    (clk),
    .clr_n  (clr_n),
    .load_i (load),
    .shift_i(shift),
    .din_i  (din),
    .sout_o (sout)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the cycle being entered, so every output is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    z_d     = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_SYNC;
          load    = 1'b1;
          busy_d  = 1'b1;
          z_d     = SYNC_PAT[SYNC_LEN-1];
        end
      end
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          z_d     = sout;
          shift   = 1'b1;
        end else begin
          z_d = SYNC_PAT[2'(SYNC_LEN - 2) - cnt_q[1:0]];
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          done_d  = (GAP == 1);
        end else begin
          z_d   = sout;
          shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          done_d = (cnt_d == GAP_LAST);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign z    = z_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire
